mem_port_arbiter: RTL and testbench

Round-robin arbiter sharing the single DDR2 transaction port (strobe/complete interface of the MIG wrapper) between two cpu_clk-domain requesters. Port 0 is the load/store unit and port 1 is instruction fetch.
Holds the winning request's address, width and data stable for the entire transaction, issues one strobe pulse and waits for transaction_complete. Captures read data and returns a one-cycle done pulse to the owner.
Sits between the CPU core and the memory wrapper, entirely in the cpu_clk domain.

---
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Round-robin sharing of the DDR2 strobe/complete port between the
//             load/store unit (port 0) and instruction fetch (port 1).
//  Option   : MEM_ARB_TIMEOUT_EN - abandon a transaction after TIMEOUT_CYCLES
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W         = 28,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              cpu_clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [1:0]        req0_width,
    input  logic [63:0]       req0_wdata,
    output logic              req0_accept,
    output logic              req0_done,
    output logic [63:0]       req0_rdata,
    output logic              req0_err,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [1:0]        req1_width,
    input  logic [63:0]       req1_wdata,
    output logic              req1_accept,
    output logic              req1_done,
    output logic [63:0]       req1_rdata,
    output logic              req1_err,

    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic [1:0]        mem_width,
    output logic [63:0]       mem_data_in,
    output logic              mem_rstrobe,
    output logic              mem_wstrobe,
    input  logic [63:0]       mem_data_out,
    input  logic              mem_complete,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;

    logic                rr_last;
    logic                owner;
    logic                hold_we;
    logic [ADDR_W-1:0]   hold_addr;
    logic [1:0]          hold_width;
    logic [63:0]         hold_wdata;
    logic [63:0]         rdata0;
    logic [63:0]         rdata1;

    logic                grant0;
    logic                grant1;
    logic                timeout_hit;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    // Both valid: the port that did not win last time gets the grant.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_IDLE && mem_ready) begin
            if (req0_valid && req1_valid) begin
                grant0 = rr_last;
                grant1 = ~rr_last;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (grant0 || grant1) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (mem_complete || timeout_hit) state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last    <= 1'b1;
            owner      <= 1'b0;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_width <= 2'd0;
            hold_wdata <= 64'd0;
            rdata0     <= 64'd0;
            rdata1     <= 64'd0;
        end else begin
            if (grant0 || grant1) begin
                owner      <= grant1;
                rr_last    <= grant1;
                hold_we    <= grant1 ? req1_we    : req0_we;
                hold_addr  <= grant1 ? req1_addr  : req0_addr;
                hold_width <= grant1 ? req1_width : req0_width;
                hold_wdata <= grant1 ? req1_wdata : req0_wdata;
            end
            if (state == ST_WAIT && mem_complete && !hold_we) begin
                if (owner) begin
                    rdata1 <= mem_data_out;
                end else begin
                    rdata0 <= mem_data_out;
                end
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    // A completion in the same cycle as the limit still counts as success.
    assign timeout_hit = (state == ST_WAIT) && !mem_complete &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
        end else begin
            if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (grant0 || grant1) begin
                timed_out <= 1'b0;
            end else if (timeout_hit) begin
                timed_out <= 1'b1;
            end
        end
    end

    assign req0_err = (state == ST_RESP) && !owner && timed_out;
    assign req1_err = (state == ST_RESP) &&  owner && timed_out;
`else
    assign timeout_hit = 1'b0;
    assign req0_err    = 1'b0;
    assign req1_err    = 1'b0;
`endif

    assign req0_accept   = grant0;
    assign req1_accept   = grant1;
    assign req0_done     = (state == ST_RESP) && !owner;
    assign req1_done     = (state == ST_RESP) &&  owner;
    assign req0_rdata    = rdata0;
    assign req1_rdata    = rdata1;

    assign mem_addr      = hold_addr;
    assign mem_read_addr = hold_addr;
    assign mem_width     = hold_width;
    assign mem_data_in   = hold_wdata;
    assign mem_rstrobe   = (state == ST_ISSUE) && !hold_we;
    assign mem_wstrobe   = (state == ST_ISSUE) &&  hold_we;
    assign busy          = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed vector bench for mem_port_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int ADDR_W = 28;
    localparam logic [1:0] W8 = 2'd0, W16 = 2'd1, W32 = 2'd2, W64 = 2'd3;

    logic              cpu_clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req0_we, req0_accept, req0_done, req0_err;
    logic [ADDR_W-1:0] req0_addr;
    logic [1:0]        req0_width;
    logic [63:0]       req0_wdata, req0_rdata;
    logic              req1_valid, req1_we, req1_accept, req1_done, req1_err;
    logic [ADDR_W-1:0] req1_addr;
    logic [1:0]        req1_width;
    logic [63:0]       req1_wdata, req1_rdata;
    logic              mem_ready, mem_rstrobe, mem_wstrobe, mem_complete, busy;
    logic [ADDR_W-1:0] mem_addr, mem_read_addr;
    logic [1:0]        mem_width;
    logic [63:0]       mem_data_in, mem_data_out;

    int n_tests = 0;
    int n_fail  = 0;
    int rstb_cnt = 0;
    int wstb_cnt = 0;
    int done_cnt = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)) dut (
        .cpu_clk(cpu_clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_width(req0_width), .req0_wdata(req0_wdata), .req0_accept(req0_accept),
        .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_width(req1_width), .req1_wdata(req1_wdata), .req1_accept(req1_accept),
        .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_read_addr(mem_read_addr),
        .mem_width(mem_width), .mem_data_in(mem_data_in), .mem_rstrobe(mem_rstrobe),
        .mem_wstrobe(mem_wstrobe), .mem_data_out(mem_data_out),
        .mem_complete(mem_complete), .busy(busy)
    );

    always #5 cpu_clk = ~cpu_clk;

    always @(posedge cpu_clk) begin
        if (mem_rstrobe) rstb_cnt++;
        if (mem_wstrobe) wstb_cnt++;
        if (req0_done || req1_done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  valid;
        logic        we0;
        logic [27:0] addr0;
        logic [1:0]  width0;
        logic [63:0] wdata0;
        logic        we1;
        logic [27:0] addr1;
        logic [1:0]  width1;
        logic [63:0] wdata1;
        int          delay;
        logic [63:0] rresp;
        logic        exp_port;
        logic [63:0] exp_rd0;
        logic [63:0] exp_rd1;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " mem_addr"}, {mem_addr, mem_read_addr, mem_width}, 0);
        check({tag, " mem_data_in"}, mem_data_in, 0);
        check({tag, " rdata0"}, req0_rdata, 0);
        check({tag, " rdata1"}, req1_rdata, 0);
        check({tag, " pulses"}, {req0_accept, req1_accept, req0_done, req1_done,
                                 req0_err, req1_err, mem_rstrobe, mem_wstrobe}, 0);
    endtask

    // Runs a transaction from the ISSUE cycle to the return to IDLE.
    task automatic finish_txn(input string tag, input logic port, input logic we,
                              input logic [27:0] addr, input logic [1:0] width,
                              input logic [63:0] wdata, input int delay,
                              input logic [63:0] rresp, input logic [63:0] exp_rd0,
                              input logic [63:0] exp_rd1);
        int rs, ws, ds, bad;
        rs = rstb_cnt; ws = wstb_cnt; ds = done_cnt; bad = 0;
        @(negedge cpu_clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({tag, " rstrobe"}, mem_rstrobe, !we);
        check({tag, " wstrobe"}, mem_wstrobe, we);
        check({tag, " mem_addr"}, mem_addr, addr);
        check({tag, " mem_read_addr"}, mem_read_addr, addr);
        check({tag, " mem_width"}, mem_width, width);
        check({tag, " mem_data_in"}, mem_data_in, wdata);
        for (int d = 1; d < delay; d++) begin
            @(negedge cpu_clk);
            if (mem_rstrobe || mem_wstrobe || req0_done || req1_done || !busy) bad++;
            if (mem_addr !== addr || mem_read_addr !== addr ||
                mem_width !== width || mem_data_in !== wdata) bad++;
        end
        @(negedge cpu_clk);
        mem_complete = 1'b1;
        mem_data_out = rresp;
        @(negedge cpu_clk);
        mem_complete = 1'b0;
        mem_data_out = 64'h0;
        check({tag, " wait_hold"}, bad, 0);
        check({tag, " done0"}, req0_done, !port);
        check({tag, " done1"}, req1_done, port);
        check({tag, " err"}, {req0_err, req1_err}, 0);
        check({tag, " rdata0"}, req0_rdata, exp_rd0);
        check({tag, " rdata1"}, req1_rdata, exp_rd1);
        check({tag, " resp_addr"}, mem_addr, addr);
        @(negedge cpu_clk);
        check({tag, " idle"}, busy, 0);
        check({tag, " done_count"}, done_cnt - ds, 1);
        check({tag, " rstrobe_count"}, rstb_cnt - rs, !we);
        check({tag, " wstrobe_count"}, wstb_cnt - ws, we);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge cpu_clk);
        req0_valid = v.valid[0]; req0_we = v.we0; req0_addr = v.addr0;
        req0_width = v.width0;   req0_wdata = v.wdata0;
        req1_valid = v.valid[1]; req1_we = v.we1; req1_addr = v.addr1;
        req1_width = v.width1;   req1_wdata = v.wdata1;
        #1;
        check({tag, " accept0"}, req0_accept, !v.exp_port);
        check({tag, " accept1"}, req1_accept, v.exp_port);
        if (v.exp_port)
            finish_txn(tag, 1'b1, v.we1, v.addr1, v.width1, v.wdata1, v.delay,
                       v.rresp, v.exp_rd0, v.exp_rd1);
        else
            finish_txn(tag, 1'b0, v.we0, v.addr0, v.width0, v.wdata0, v.delay,
                       v.rresp, v.exp_rd0, v.exp_rd1);
    endtask

    vec_t vecs[6];
    vec_t vlast;

    initial begin
        int acc, stb, ds, k;

        vecs[0] = '{valid:2'b11, we0:1'b0, addr0:28'h400, width0:W32, wdata0:64'h0,
                    we1:1'b0, addr1:28'h800, width1:W16, wdata1:64'h0, delay:2,
                    rresp:64'h00000000CAFEF00D, exp_port:1'b0,
                    exp_rd0:64'h00000000CAFEF00D, exp_rd1:64'h0};
        vecs[1] = '{valid:2'b11, we0:1'b1, addr0:28'h404, width0:W32, wdata0:64'h11111111,
                    we1:1'b0, addr1:28'h804, width1:W64, wdata1:64'h0, delay:4,
                    rresp:64'h0123456789ABCDEF, exp_port:1'b1,
                    exp_rd0:64'h00000000CAFEF00D, exp_rd1:64'h0123456789ABCDEF};
        vecs[2] = '{valid:2'b11, we0:1'b0, addr0:28'h408, width0:W64, wdata0:64'h0,
                    we1:1'b1, addr1:28'h808, width1:W16, wdata1:64'hBEEF, delay:1,
                    rresp:64'hA5A5A5A55A5A5A5A, exp_port:1'b0,
                    exp_rd0:64'hA5A5A5A55A5A5A5A, exp_rd1:64'h0123456789ABCDEF};
        vecs[3] = '{valid:2'b11, we0:1'b0, addr0:28'h40C, width0:W8, wdata0:64'h0,
                    we1:1'b1, addr1:28'h80C, width1:W8, wdata1:64'h77, delay:3,
                    rresp:64'hDEADDEADDEADDEAD, exp_port:1'b1,
                    exp_rd0:64'hA5A5A5A55A5A5A5A, exp_rd1:64'h0123456789ABCDEF};
        vecs[4] = '{valid:2'b01, we0:1'b0, addr0:28'h0000100, width0:W64, wdata0:64'h0,
                    we1:1'b0, addr1:28'h0, width1:W8, wdata1:64'h0, delay:5,
                    rresp:64'h1122334455667788, exp_port:1'b0,
                    exp_rd0:64'h1122334455667788, exp_rd1:64'h0123456789ABCDEF};
        vecs[5] = '{valid:2'b10, we0:1'b0, addr0:28'h0, width0:W8, wdata0:64'h0,
                    we1:1'b1, addr1:28'h0000203, width1:W8, wdata1:64'hAB, delay:3,
                    rresp:64'hFFFFFFFFFFFFFFFF, exp_port:1'b1,
                    exp_rd0:64'h1122334455667788, exp_rd1:64'h0123456789ABCDEF};

        rst_n = 1'b0;
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_width = 0; req0_wdata = 0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_width = 0; req1_wdata = 0;
        mem_ready = 1'b1; mem_complete = 1'b0; mem_data_out = 64'h0;
        repeat (3) @(negedge cpu_clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Memory not ready: request must wait, then go on the next cycle.
        @(negedge cpu_clk);
        mem_ready = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 28'h040; req0_width = W32;
        acc = 0; stb = rstb_cnt + wstb_cnt;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_accept || req1_accept || busy) acc++;
            @(negedge cpu_clk);
        end
        check("not_ready accept", acc, 0);
        check("not_ready strobe", rstb_cnt + wstb_cnt - stb, 0);
        mem_ready = 1'b1;
        #1;
        check("ready accept0", req0_accept, 1);
        finish_txn("ready_txn", 1'b0, 1'b0, 28'h040, W32, 64'h0, 2,
                   64'h5555, 64'h5555, 64'h0);

        // Reset asserted while waiting for completion.
        @(negedge cpu_clk);
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 28'h300; req1_width = W32;
        req1_wdata = 64'h12345678;
        #1;
        check("rst_txn accept1", req1_accept, 1);
        ds = done_cnt;
        @(negedge cpu_clk);
        req1_valid = 1'b0;
        repeat (2) @(negedge cpu_clk);
        check("rst_txn waiting", busy, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(negedge cpu_clk);
        rst_n = 1'b1;
        repeat (3) @(negedge cpu_clk);
        mem_complete = 1'b1; mem_data_out = 64'h99;
        @(negedge cpu_clk);
        mem_complete = 1'b0; mem_data_out = 64'h0;
        repeat (2) @(negedge cpu_clk);
        check("post_reset done_count", done_cnt - ds, 0);
        check_all_zero("post_reset");

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

`ifdef MEM_ARB_TIMEOUT_EN
        @(negedge cpu_clk);
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 28'h500; req0_width = W64;
        #1;
        check("to accept0", req0_accept, 1);
        ds = done_cnt;
        @(negedge cpu_clk);
        req0_valid = 1'b0;
        k = 0;
        while (k < 40 && !req0_done) begin
            @(negedge cpu_clk);
            k++;
        end
        check("to done_cycle", k, 17);
        check("to err", req0_err, 1);
        check("to rdata0", req0_rdata, 64'h1122334455667788);
        repeat (2) @(negedge cpu_clk);
        mem_complete = 1'b1; mem_data_out = 64'h4242;
        @(negedge cpu_clk);
        mem_complete = 1'b0; mem_data_out = 64'h0;
        @(negedge cpu_clk);
        check("late_complete done_count", done_cnt - ds, 1);
        check("late_complete idle", busy, 0);
        vlast = '{valid:2'b10, we0:1'b0, addr0:28'h0, width0:W8, wdata0:64'h0,
                  we1:1'b0, addr1:28'h600, width1:W64, wdata1:64'h0, delay:2,
                  rresp:64'h0F0F0F0F0F0F0F0F, exp_port:1'b1,
                  exp_rd0:64'h1122334455667788, exp_rd1:64'h0F0F0F0F0F0F0F0F};
`else
        k = 0;
        ds = 0;
        vlast = '{valid:2'b01, we0:1'b0, addr0:28'h500, width0:W64, wdata0:64'h0,
                  we1:1'b0, addr1:28'h0, width1:W8, wdata1:64'h0, delay:40,
                  rresp:64'h0BADF00D0BADF00D, exp_port:1'b0,
                  exp_rd0:64'h0BADF00D0BADF00D, exp_rd1:64'h0123456789ABCDEF};
`endif
        run_vec(6, vlast);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
